counter_ts_extender: RTL and testbench
======================================

// Module: counter_ts_extender
// PURPOSE
//  Downstream stage of the 8-bit enable/clear counter. Consumes its count and OV flag,
//  extends the count with an overflow-driven high word into a wide timestamp, and serves
//  timestamp snapshots over a valid/ready handshake. Also raises a one-cycle compare-match
//  pulse. Shares clk, Reset and CLR with the counter it monitors.
// PARAMETERS
//  CNT_WIDTH  8   width of the low word (counter input)
//  HI_WIDTH   16  width of the overflow-count high word; TS_W = HI_WIDTH+CNT_WIDTH
// PORTS
//  clk        in   1          system clock, rising edge
//  Reset      in   1          asynchronous, active-low reset
//  counter    in   CNT_WIDTH  live count from the counter stage
//  OV         in   1          overflow flag from the counter stage
//  CLR        in   1          synchronous clear, same signal as the counter's CLR
//  snap_req   in   1          snapshot request, sampled each cycle
//  ts_valid   out  1          snapshot available
//  ts_ready   in   1          consumer accepts snapshot when ts_valid & ts_ready
//  ts_data    out  TS_W       snapshot {hi, counter}
//  snap_drop  out  1          1-cycle pulse: request discarded (no room)
//  hi_wrap    out  1          sticky: high word wrapped past all-ones
//  cmp_en     in   1          compare enable
//  cmp_value  in   TS_W       compare value
//  cmp_hit    out  1          1-cycle pulse on compare match
// BEHAVIOUR
//  Reset low (async): hi=0, ov_d=0, hi_wrap=0, ts_valid=0, ts_data=0, pending=0,
//   snap_drop=0, cmp_hit=0, match_d=0, FSM=IDLE; takes effect immediately, mid-handshake too.
//  ov_rise = OV & ~ov_d; ov_d <= OV each cycle. Multi-cycle OV counts once.
//  High word: on ov_rise hi <= hi+1 (mod 2^HI_WIDTH); at hi=all-ones it wraps to 0, sets hi_wrap.
//  CLR=1: hi<=0, hi_wrap<=0, ov_d<=0; CLR overrides ov_rise in the same cycle.
//   CLR does not touch the FSM; a held snapshot stays valid and stable.
//  Live timestamp ts_live = {hi + ov_rise, counter}: corrects the cycle where counter has
//   already wrapped to 0 but hi has not yet incremented. Used by capture and compare.
//   When CLR=1: ts_live = {0, counter}.
//  Capture: ts_data <= ts_live; snapshot appears 1 cycle after the capturing edge.
//  FSM states IDLE, VALID, VALID_PEND (pending = one-deep request flag):
//   IDLE:  snap_req -> capture, ts_valid<=1, VALID.
//   VALID: ts_data held stable while ts_valid=1 & ts_ready=0.
//     ready & req  -> capture new value, stay VALID (back-to-back, no bubble).
//     ready & !req -> ts_valid<=0, IDLE.
//     !ready & req -> pending<=1, VALID_PEND.
//   VALID_PEND: ready -> capture at this edge (value of the accept cycle), pending<=0, VALID.
//     Any req without ready -> snap_drop pulse next cycle. ready & req -> capture, snap_drop.
//  Compare: match = cmp_en & (ts_live == cmp_value); match_d <= match;
//   cmp_hit <= match & ~match_d (rising match only, 1-cycle latency).
//   Stalled counter holding the match value gives a single pulse.
//  All arithmetic unsigned, modulo width; no saturation.
// TESTING
//  1 Reset high, EN=1, CLR=0; after 3 OV events snap_req at counter=0x05 -> ts_data=0x0305,
//    ts_valid next cycle.
//  2 snap_req in the cycle counter=0x00, OV=1, hi=2 -> ts_data=0x0300 (not 0x0200).
//  3 ts_ready=0; snap_req at t0,t3,t5 -> ts_valid stays 1, data stable; snap_drop at t6;
//    ts_ready=1 at t8 -> t0 value accepted, t8 value presented at t9.
//  4 force hi=16'hFFFF, then OV rise -> hi=0, hi_wrap=1; CLR pulse -> hi_wrap=0, hi=0.
//  5 cmp_en=1, cmp_value=0x0110 -> cmp_hit pulse exactly once, 1 cycle after ts_live=0x0110;
//    hold EN=0 at 0x10 -> no further pulse.
//  6 Reset low while FSM=VALID_PEND -> ts_valid, pending, hi drop to 0 immediately;
//    after release, first snap_req behaves as from IDLE.

Source files
------------

// File: rtl/counter_ts_extender.sv
// Timestamp extender: widens an 8-bit counter with an overflow-driven high word,
// serves snapshots over valid/ready, and pulses on a compare match.
module counter_ts_extender #(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned HI_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic [CNT_WIDTH-1:0]          counter,
  input  logic                          OV,
  input  logic                          CLR,
  input  logic                          snap_req,
  output logic                          ts_valid,
  input  logic                          ts_ready,
  output logic [HI_WIDTH+CNT_WIDTH-1:0] ts_data,
  output logic                          snap_drop,
  output logic                          hi_wrap,
  input  logic                          cmp_en,
  input  logic [HI_WIDTH+CNT_WIDTH-1:0] cmp_value,
  output logic                          cmp_hit
);

  localparam int unsigned TS_W = HI_WIDTH + CNT_WIDTH;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] VALID      = 2'd1;
  localparam logic [1:0] VALID_PEND = 2'd2;

  logic [HI_WIDTH-1:0] hi;
  logic [HI_WIDTH-1:0] hi_live;
  logic [TS_W-1:0]     ts_live;
  logic                ov_d;
  logic                ov_rise;
  logic                match;
  logic                match_d;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                valid_nxt;
  logic                pending;
  logic                pending_nxt;
  logic                capture;
  logic                drop_nxt;

  assign ov_rise = OV & ~ov_d;

  // Live timestamp: pre-apply this cycle's overflow so a just-wrapped counter reads correctly
  always_comb begin
    hi_live = CLR ? '0 : hi + HI_WIDTH'(ov_rise);
    ts_live = {hi_live, counter};
  end

  // High word, overflow edge detector and sticky wrap flag; CLR dominates
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      hi      <= '0;
      ov_d    <= 1'b0;
      hi_wrap <= 1'b0;
    end else if (CLR) begin
      hi      <= '0;
      ov_d    <= 1'b0;
      hi_wrap <= 1'b0;
    end else begin
      ov_d <= OV;
      if (ov_rise) begin
        hi <= hi + HI_WIDTH'(1);
        if (hi == '1) hi_wrap <= 1'b1;
      end
    end
  end

  // Snapshot handshake next-state logic with a one-deep pending request
  always_comb begin
    state_nxt   = state;
    valid_nxt   = ts_valid;
    pending_nxt = pending;
    capture     = 1'b0;
    drop_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (snap_req) begin
          capture   = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = VALID;
        end
      end
      VALID: begin
        if (ts_ready) begin
          if (snap_req) begin
            capture = 1'b1;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end else if (snap_req) begin
          pending_nxt = 1'b1;
          state_nxt   = VALID_PEND;
        end
      end
      VALID_PEND: begin
        // Pending slot is full, so any new request here is discarded
        drop_nxt = snap_req;
        if (ts_ready) begin
          capture     = 1'b1;
          pending_nxt = 1'b0;
          state_nxt   = VALID;
        end
      end
      default: begin
        state_nxt   = IDLE;
        valid_nxt   = 1'b0;
        pending_nxt = 1'b0;
      end
    endcase
  end

  // Snapshot FSM state and registered handshake outputs
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      ts_valid  <= 1'b0;
      pending   <= 1'b0;
      snap_drop <= 1'b0;
      ts_data   <= '0;
    end else begin
      state     <= state_nxt;
      ts_valid  <= valid_nxt;
      pending   <= pending_nxt;
      snap_drop <= drop_nxt;
      if (capture) ts_data <= ts_live;
    end
  end

  assign match = cmp_en & (ts_live == cmp_value);

  // Compare pulse on the rising edge of a match only
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      match_d <= 1'b0;
      cmp_hit <= 1'b0;
    end else begin
      match_d <= match;
      cmp_hit <= match & ~match_d;
    end
  end

endmodule

// File: tb/tb_counter_ts_extender.sv
// Directed bench for counter_ts_extender: vector table plus reset and wrap sequences.
module tb_counter_ts_extender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  counter;
  logic        ov, clr, snap_req, ts_ready, cmp_en;
  logic [23:0] cmp_value;
  logic        ts_valid, snap_drop, hi_wrap, cmp_hit;
  logic [23:0] ts_data;

  // Narrow-high-word instance so the wrap can be reached in a few cycles
  logic        s_valid, s_drop, s_wrap, s_hit;
  logic [11:0] s_data;
  logic [11:0] s_cmp_value = 12'h000;
  logic        s_cmp_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_ts_extender dut (
    .clk(clk), .Reset(rst_n), .counter(counter), .OV(ov), .CLR(clr),
    .snap_req(snap_req), .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data),
    .snap_drop(snap_drop), .hi_wrap(hi_wrap), .cmp_en(cmp_en), .cmp_value(cmp_value),
    .cmp_hit(cmp_hit)
  );

  counter_ts_extender #(.CNT_WIDTH(8), .HI_WIDTH(4)) dut_s (
    .clk(clk), .Reset(rst_n), .counter(counter), .OV(ov), .CLR(clr),
    .snap_req(snap_req), .ts_valid(s_valid), .ts_ready(ts_ready), .ts_data(s_data),
    .snap_drop(s_drop), .hi_wrap(s_wrap), .cmp_en(s_cmp_en), .cmp_value(s_cmp_value),
    .cmp_hit(s_hit)
  );

  typedef struct packed {
    logic        ov;
    logic        clr;
    logic [7:0]  cnt;
    logic        req;
    logic        rdy;
    logic        cen;
    logic [23:0] cval;
    logic        e_valid;
    logic [23:0] e_data;
    logic        e_drop;
    logic        e_hit;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic o, input logic c, input logic [7:0] n,
                              input logic rq, input logic rd, input logic ce,
                              input logic [23:0] cv, input logic ev,
                              input logic [23:0] ed, input logic edr, input logic eh);
    vec_t v;
    v.ov = o; v.clr = c; v.cnt = n; v.req = rq; v.rdy = rd; v.cen = ce; v.cval = cv;
    v.e_valid = ev; v.e_data = ed; v.e_drop = edr; v.e_hit = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; counter = 8'h00; ov = 1'b0; clr = 1'b0; snap_req = 1'b0;
    ts_ready = 1'b0; cmp_en = 1'b0; cmp_value = 24'h0;

    //             ov clr cnt    req rdy cen cval       valid data       drop hit
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 24'h0,      0, 24'h000000, 0, 0)); // 0  hi=1
    vecs.push_back(mk(0, 0, 8'h01, 0, 0, 0, 24'h0,      0, 24'h000000, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 24'h0,      0, 24'h000000, 0, 0)); // hi=2
    vecs.push_back(mk(0, 0, 8'h01, 0, 0, 0, 24'h0,      0, 24'h000000, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 24'h0,      0, 24'h000000, 0, 0)); // hi=3
    vecs.push_back(mk(0, 0, 8'h05, 1, 0, 0, 24'h0,      1, 24'h000305, 0, 0)); // 5  snap
    vecs.push_back(mk(0, 0, 8'h06, 0, 1, 0, 24'h0,      0, 24'h000305, 0, 0)); // accept
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 24'h0,      1, 24'h000400, 0, 0)); // 7  wrap-cycle snap (t0)
    vecs.push_back(mk(1, 0, 8'h01, 0, 0, 0, 24'h0,      1, 24'h000400, 0, 0)); // held OV: no count
    vecs.push_back(mk(0, 0, 8'h02, 0, 0, 0, 24'h0,      1, 24'h000400, 0, 0));
    vecs.push_back(mk(0, 0, 8'h03, 1, 0, 0, 24'h0,      1, 24'h000400, 0, 0)); // 10 t3 -> pending
    vecs.push_back(mk(0, 0, 8'h04, 0, 0, 0, 24'h0,      1, 24'h000400, 0, 0));
    vecs.push_back(mk(0, 0, 8'h05, 1, 0, 0, 24'h0,      1, 24'h000400, 1, 0)); // t5 -> drop
    vecs.push_back(mk(0, 0, 8'h06, 0, 0, 0, 24'h0,      1, 24'h000400, 0, 0));
    vecs.push_back(mk(0, 0, 8'h07, 0, 0, 0, 24'h0,      1, 24'h000400, 0, 0));
    vecs.push_back(mk(0, 0, 8'h08, 0, 1, 0, 24'h0,      1, 24'h000408, 0, 0)); // 15 t8 accept
    vecs.push_back(mk(0, 0, 8'h09, 1, 1, 0, 24'h0,      1, 24'h000409, 0, 0)); // back-to-back
    vecs.push_back(mk(0, 0, 8'h0A, 1, 0, 0, 24'h0,      1, 24'h000409, 0, 0)); // pending
    vecs.push_back(mk(0, 0, 8'h0B, 1, 1, 0, 24'h0,      1, 24'h00040B, 1, 0)); // capture+drop
    vecs.push_back(mk(0, 0, 8'h0C, 0, 1, 0, 24'h0,      0, 24'h00040B, 0, 0));
    vecs.push_back(mk(0, 0, 8'h0F, 0, 0, 1, 24'h000410, 0, 24'h00040B, 0, 0)); // 20 compare
    vecs.push_back(mk(0, 0, 8'h10, 0, 0, 1, 24'h000410, 0, 24'h00040B, 0, 1));
    vecs.push_back(mk(0, 0, 8'h10, 0, 0, 1, 24'h000410, 0, 24'h00040B, 0, 0)); // stalled
    vecs.push_back(mk(0, 0, 8'h10, 0, 0, 1, 24'h000410, 0, 24'h00040B, 0, 0));
    vecs.push_back(mk(0, 0, 8'h11, 0, 0, 1, 24'h000410, 0, 24'h00040B, 0, 0));
    vecs.push_back(mk(0, 0, 8'h10, 0, 0, 0, 24'h000410, 0, 24'h00040B, 0, 0)); // disabled
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 24'h0,      1, 24'h000000, 0, 0)); // 26 CLR snap
    vecs.push_back(mk(0, 0, 8'h01, 0, 1, 0, 24'h0,      0, 24'h000000, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 24'h0,      1, 24'h000100, 0, 0)); // hi=1
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 24'h0,      1, 24'h000100, 0, 0)); // CLR keeps snapshot
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 24'h0,      0, 24'h000100, 0, 0)); // ov_d cleared: new rise
    vecs.push_back(mk(0, 0, 8'h02, 1, 0, 0, 24'h0,      1, 24'h000102, 0, 0)); // 31

    // Reset state
    #12;
    chk("rst_valid", 24'(ts_valid), 24'h0);
    chk("rst_data", ts_data, 24'h0);
    chk("rst_drop", 24'(snap_drop), 24'h0);
    chk("rst_hit", 24'(cmp_hit), 24'h0);
    chk("rst_wrap", 24'(hi_wrap), 24'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table vectors: outputs checked after the edge that consumed the vector's inputs
    foreach (vecs[i]) begin
      ov = vecs[i].ov; clr = vecs[i].clr; counter = vecs[i].cnt;
      snap_req = vecs[i].req; ts_ready = vecs[i].rdy;
      cmp_en = vecs[i].cen; cmp_value = vecs[i].cval;
      tick();
      chk($sformatf("v%0d_valid", i), 24'(ts_valid), 24'(vecs[i].e_valid));
      chk($sformatf("v%0d_data", i), ts_data, vecs[i].e_data);
      chk($sformatf("v%0d_drop", i), 24'(snap_drop), 24'(vecs[i].e_drop));
      chk($sformatf("v%0d_hit", i), 24'(cmp_hit), 24'(vecs[i].e_hit));
      chk($sformatf("v%0d_wrap", i), 24'(hi_wrap), 24'h0);
    end

    // Async reset while a request is pending
    snap_req = 1'b1; ts_ready = 1'b0; counter = 8'h03;
    tick();
    snap_req = 1'b0;
    chk("pend_valid", 24'(ts_valid), 24'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 24'(ts_valid), 24'h0);
    chk("arst_data", ts_data, 24'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    snap_req = 1'b1; counter = 8'h44;
    tick();
    chk("post_rst_valid", 24'(ts_valid), 24'h1);
    chk("post_rst_data", ts_data, 24'h000044);
    snap_req = 1'b0; ts_ready = 1'b1;
    tick();
    chk("post_rst_idle", 24'(ts_valid), 24'h0);

    // High word wrap on the narrow instance (16 overflow events)
    ts_ready = 1'b0; counter = 8'h00;
    for (int k = 0; k < 16; k++) begin
      ov = 1'b1; tick();
      ov = 1'b0; tick();
      if (k == 14) chk("wrap_before", 24'(s_wrap), 24'h0);
    end
    chk("wrap_set", 24'(s_wrap), 24'h1);
    chk("wide_no_wrap", 24'(hi_wrap), 24'h0);
    snap_req = 1'b1; counter = 8'h22;
    tick();
    chk("wrap_hi_zero", 24'(s_data), 24'h000022);
    chk("wide_hi_16", ts_data, 24'h001022);
    snap_req = 1'b0; clr = 1'b1; ts_ready = 1'b1;
    tick();
    chk("clr_wrap", 24'(s_wrap), 24'h0);
    clr = 1'b0; ts_ready = 1'b0; snap_req = 1'b1; counter = 8'h33;
    tick();
    chk("clr_hi_narrow", 24'(s_data), 24'h000033);
    chk("clr_hi_wide", ts_data, 24'h000033);
    snap_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
